// File: rtl/cpu_ctrl_fsm_pkg.sv
// cpu_pkg: shared definitions for the instruction-cycle controller.
//   OPC_W    : opcode width (IR[15:13])
//   HLT..JMP : opcode values
//   state_e  : one-hot controller state encoding (IDLE, S0..S7, HALT)
//   is_alu   : true for opcodes that read memory into the ALU path
package cpu_pkg;

  localparam int unsigned OPC_W = 3;

  localparam logic [OPC_W-1:0] HLT = OPC_W'(0);
  localparam logic [OPC_W-1:0] SKZ = OPC_W'(1);
  localparam logic [OPC_W-1:0] ADD = OPC_W'(2);
  localparam logic [OPC_W-1:0] AND = OPC_W'(3);
  localparam logic [OPC_W-1:0] XOR = OPC_W'(4);
  localparam logic [OPC_W-1:0] LDA = OPC_W'(5);
  localparam logic [OPC_W-1:0] STO = OPC_W'(6);
  localparam logic [OPC_W-1:0] JMP = OPC_W'(7);

  typedef enum logic [9:0] {
    IDLE = 10'b00_0000_0001,
    S0   = 10'b00_0000_0010,
    S1   = 10'b00_0000_0100,
    S2   = 10'b00_0000_1000,
    S3   = 10'b00_0001_0000,
    S4   = 10'b00_0010_0000,
    S5   = 10'b00_0100_0000,
    S6   = 10'b00_1000_0000,
    S7   = 10'b01_0000_0000,
    HALT = 10'b10_0000_0000
  } state_e;

  function automatic logic is_alu(input logic [OPC_W-1:0] opc);
    return (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA);
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// cpu_ctrl_fsm_if: controller <-> datapath signal bundle.
//   fetch, opcode, zero        : status into the controller
//   inc_pc, load_pc, load_ir,
//   load_acc, rd, wr,
//   datactl_ena, halt          : datapath enables out of the controller
// Modports: master = controller side, slave = datapath/clock-gen side.
interface cpu_ctrl_fsm_if #(
  parameter int unsigned OPC_W = 3
);
  logic             fetch;
  logic [OPC_W-1:0] opcode;
  logic             zero;
  logic             inc_pc;
  logic             load_pc;
  logic             load_ir;
  logic             load_acc;
  logic             rd;
  logic             wr;
  logic             datactl_ena;
  logic             halt;

  modport master (
    input  fetch, opcode, zero,
    output inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );

  modport slave (
    output fetch, opcode, zero,
    input  inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt
  );
endinterface

// File: rtl/cpu_ctrl_fsm_fetch_edge_det.sv
// fetch_edge_det: registered rising-edge detector for the fetch strobe.
//   clk, rst : clock, synchronous active-high reset
//   fetch    : fetch strobe from the clock generator
//   rise     : fetch & ~fetch_q (combinational, same cycle as the rise)
module fetch_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic fetch,
  output logic rise
);

  logic fetch_q;
  logic fetch_d;

  always_comb begin
    fetch_d = fetch;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_q <= 1'b0;
    end else begin
      fetch_q <= fetch_d;
    end
  end

  assign rise = fetch & ~fetch_q;

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: 8-clock instruction-cycle controller.
//   clk, rst : clock, synchronous active-high reset
//   bus      : cpu_ctrl_fsm_if.master (fetch/opcode/zero in, enables out)
// Optional build macro: CTRL_RESYNC_EN -- when defined, S7 only continues
// to S0 if a fetch rise is seen; otherwise it drops to IDLE to realign.
module cpu_ctrl_fsm
  import cpu_pkg::*;
#(
  parameter int unsigned OPC_W = cpu_pkg::OPC_W
) (
  input  logic           clk,
  input  logic           rst,
  cpu_ctrl_fsm_if.master bus
);

  state_e           state_q;
  state_e           state_d;
  logic             fetch_rise;
  logic [OPC_W-1:0] opc;
  logic             zero;

  logic inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt;

  assign opc  = bus.opcode;
  assign zero = bus.zero;

  fetch_edge_det u_fetch_edge_det (
    .clk   (clk),
    .rst   (rst),
    .fetch (bus.fetch),
    .rise  (fetch_rise)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = fetch_rise ? S0 : IDLE;
      S0:   state_d = S1;
      S1:   state_d = S2;
      S2:   state_d = S3;
      S3:   state_d = (opc == HLT) ? HALT : S4;
      S4:   state_d = S5;
      S5:   state_d = S6;
      S6:   state_d = S7;
`ifdef CTRL_RESYNC_EN
      // A missing rise at S7 means the clock generator period slipped;
      // wait in IDLE for the next rise rather than run misaligned.
      S7:   state_d = fetch_rise ? S0 : IDLE;
`else
      S7:   state_d = S0;
`endif
      HALT: state_d = HALT;
      // Non-one-hot encodings are recovered to IDLE.
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    inc_pc      = 1'b0;
    load_pc     = 1'b0;
    load_ir     = 1'b0;
    load_acc    = 1'b0;
    rd          = 1'b0;
    wr          = 1'b0;
    datactl_ena = 1'b0;
    halt        = 1'b0;
    case (state_q)
      S0: begin
        rd      = 1'b1;
        load_ir = 1'b1;
      end
      S1: begin
        rd      = 1'b1;
        load_ir = 1'b1;
        inc_pc  = 1'b1;
      end
      S3: inc_pc = (opc != HLT);
      S4: begin
        if (is_alu(opc)) rd          = 1'b1;
        if (opc == JMP)  load_pc     = 1'b1;
        if (opc == STO)  datactl_ena = 1'b1;
      end
      S5: begin
        if (is_alu(opc)) begin
          rd       = 1'b1;
          load_acc = 1'b1;
        end
        if (opc == JMP)          load_pc     = 1'b1;
        if (opc == STO)          datactl_ena = 1'b1;
        if ((opc == SKZ) && zero) inc_pc     = 1'b1;
      end
      S6: begin
        if (opc == STO) begin
          wr          = 1'b1;
          datactl_ena = 1'b1;
        end
        if ((opc == SKZ) && zero) inc_pc = 1'b1;
      end
      S7: begin
        if (opc == STO) datactl_ena = 1'b1;
      end
      HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign bus.inc_pc      = inc_pc;
  assign bus.load_pc     = load_pc;
  assign bus.load_ir     = load_ir;
  assign bus.load_acc    = load_acc;
  assign bus.rd          = rd;
  assign bus.wr          = wr;
  assign bus.datactl_ena = datactl_ena;
  assign bus.halt        = halt;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Testbench for cpu_ctrl_fsm: directed instruction scenarios plus random
// opcode/zero/reset/fetch-period stimulus, checked every cycle against a
// phase-counter model of the instruction cycle.
module tb_cpu_ctrl_fsm;

`ifdef CTRL_RESYNC_EN
  localparam bit RESYNC = 1'b1;
`else
  localparam bit RESYNC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       fetch;
  logic [2:0] opcode;
  logic       zero;

  cpu_ctrl_fsm_if #(.OPC_W(3)) bus ();

  assign bus.fetch  = fetch;
  assign bus.opcode = opcode;
  assign bus.zero   = zero;

  cpu_ctrl_fsm #(.OPC_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: -1 idle, 0..7 cycle position, 8 halted.
  int   m_ph    = -1;
  logic m_fprev = 1'b0;

  // Fetch generator: high for the first 4 clocks of each period.
  bit fgen     = 1'b0;
  int fcnt     = 0;
  int fper     = 8;
  int next_per = 8;

  bit   acc_en = 1'b0;
  int   acc_idx;
  int   c_rd, c_ir, c_inc, c_acc, c_wr, c_dc, c_halt, c_zero;
  logic [7:0] wr_mask;

  // Packed as {inc_pc, load_pc, load_ir, load_acc, rd, wr, datactl_ena, halt}
  function automatic logic [7:0] dut_out();
    return {bus.inc_pc, bus.load_pc, bus.load_ir, bus.load_acc,
            bus.rd, bus.wr, bus.datactl_ena, bus.halt};
  endfunction

  function automatic logic [7:0] model_out(int ph, logic [2:0] opc, logic z);
    logic ip, lp, li, la, r, w, d, h;
    logic alu;
    ip = 0; lp = 0; li = 0; la = 0; r = 0; w = 0; d = 0; h = 0;
    alu = (opc >= 3'd2) && (opc <= 3'd5);
    if (ph == 8) h = 1;
    else if (ph == 0 || ph == 1) begin
      r = 1; li = 1; ip = (ph == 1);
    end else if (ph == 3) ip = (opc != 3'd0);
    else if (ph >= 4 && ph <= 7) begin
      if (opc == 3'd6) begin
        d = 1; w = (ph == 6);
      end else if (opc == 3'd7) lp = (ph == 4 || ph == 5);
      else if (alu) begin
        r = (ph == 4 || ph == 5); la = (ph == 5);
      end else if (opc == 3'd1) ip = z && (ph == 5 || ph == 6);
    end
    return {ip, lp, li, la, r, w, d, h};
  endfunction

  task automatic model_clock();
    logic rise;
    rise = fetch && !m_fprev;
    if (rst) begin
      m_ph    = -1;
      m_fprev = 1'b0;
    end else begin
      m_fprev = fetch;
      if (m_ph == -1)                        m_ph = rise ? 0 : -1;
      else if (m_ph == 8)                    m_ph = 8;
      else if (m_ph == 3 && opcode == 3'd0)  m_ph = 8;
      else if (m_ph == 7)                    m_ph = RESYNC ? (rise ? 0 : -1) : 0;
      else                                   m_ph = m_ph + 1;
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    logic [7:0] got, exp;
    @(negedge clk);
    got = dut_out();
    exp = model_out(m_ph, opcode, zero);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL cycle_out t=%0t ph=%0d opc=%0d zero=%0b got=%b expected=%b",
               $time, m_ph, opcode, zero, got, exp);
    end
    if (acc_en) begin
      c_inc  += int'(got[7]);
      c_ir   += int'(got[5]);
      c_acc  += int'(got[4]);
      c_rd   += int'(got[3]);
      c_wr   += int'(got[2]);
      c_dc   += int'(got[1]);
      c_halt += int'(got[0]);
      c_zero += int'(got == 8'd0);
      if (got[2] && acc_idx < 8) wr_mask[acc_idx] = 1'b1;
      acc_idx++;
    end
    @(posedge clk);
    model_clock();
    #1;
    if (fgen) begin
      fcnt = fcnt + 1;
      if (fcnt >= fper) begin
        fcnt = 0;
        fper = next_per;
      end
    end
    fetch = fgen && (fcnt < 4);
  endtask

  task automatic window(input int n);
    c_rd = 0; c_ir = 0; c_inc = 0; c_acc = 0;
    c_wr = 0; c_dc = 0; c_halt = 0; c_zero = 0;
    wr_mask = '0;
    acc_idx = 0;
    acc_en  = 1'b1;
    repeat (n) tick();
    acc_en = 1'b0;
  endtask

  // Reset with fetch low, then raise fetch so S0 follows the next edge.
  task automatic start_run(input logic [2:0] opc, input logic z, input int per);
    rst  = 1'b1;
    fgen = 1'b0;
    fetch = 1'b0;
    tick();
    rst      = 1'b0;
    opcode   = opc;
    zero     = z;
    fgen     = 1'b1;
    fcnt     = 0;
    fper     = per;
    next_per = 8;
    fetch    = 1'b1;
    tick();
  endtask

  initial begin
    rst = 1'b1; fetch = 1'b0; opcode = 3'd0; zero = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("reset_outputs", int'(dut_out()), 0);

    // ADD: two full instruction cycles
    start_run(3'd2, 1'b0, 8);
    window(8);
    chk("add_rd", c_rd, 4);
    chk("add_load_ir", c_ir, 2);
    chk("add_inc_pc", c_inc, 2);
    chk("add_load_acc", c_acc, 1);
    chk("add_wr", c_wr, 0);
    window(8);
    chk("add_reenter_rd", c_rd, 4);

    // STO
    start_run(3'd6, 1'b0, 8);
    window(8);
    chk("sto_datactl", c_dc, 4);
    chk("sto_wr", c_wr, 1);
    chk("sto_wr_s6_only", int'(wr_mask), 8'b0100_0000);
    chk("sto_rd", c_rd, 2);

    // SKZ
    start_run(3'd1, 1'b1, 8);
    window(8);
    chk("skz_zero1_inc", c_inc, 4);
    start_run(3'd1, 1'b0, 8);
    window(8);
    chk("skz_zero0_inc", c_inc, 2);

    // HLT: S0..S3, then halt held while fetch keeps toggling
    start_run(3'd0, 1'b0, 8);
    window(4);
    chk("hlt_inc_pc", c_inc, 1);
    window(24);
    chk("hlt_halt_held", c_halt, 24);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hlt_reset_outputs", int'(dut_out()), 0);

    // LDA with reset in S5
    start_run(3'd5, 1'b0, 8);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lda_rst_no_load_acc", int'(bus.load_acc), 0);
    chk("lda_rst_outputs", int'(dut_out()), 0);
    window(2);
    chk("lda_idle_wait", c_zero, 2);
    window(1);
    chk("lda_restart_rd", c_rd, 1);

    // One 10-clock fetch period on an ADD stream
    start_run(3'd2, 1'b0, 10);
    window(20);
    chk("stretch_quiet_cycles", c_zero, RESYNC ? 8 : 7);

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      opcode   = ($urandom_range(0, 99) < 3) ? 3'd0 : 3'($urandom_range(1, 7));
      zero     = 1'($urandom_range(0, 1));
      rst      = ($urandom_range(0, 99) == 0);
      next_per = ($urandom_range(0, 9) == 0) ? int'($urandom_range(7, 11)) : 8;
      tick();
    end
    rst = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
